// File: rtl/cpu_state_dumper.sv
// Architectural-state dumper: snapshots counters/PC on a trigger, then streams regfile and dmem words.
// Optional build macro DUMP_PERIODIC_EN adds an auto-trigger every PERIOD running cycles.
module cpu_state_dumper #(
  parameter int NUM_REGS  = 32,
  parameter int MEM_WORDS = 8,
  parameter int CNT_W     = 32,
  parameter int PERIOD    = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        trig_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  output logic [4:0]  reg_addr_o,
  input  logic [31:0] reg_data_i,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_data_i,
  output logic        dump_valid_o,
  input  logic        dump_ready_i,
  output logic [31:0] dump_data_o,
  output logic [7:0]  dump_tag_o,
  output logic        dump_last_o,
  output logic        busy_o,
  output logic        freeze_o
);
  localparam int L = 3 + NUM_REGS + MEM_WORDS;
  localparam logic [7:0] LAST_TAG = 8'(L);
  localparam logic [7:0] REG_BASE = 8'd4;
  localparam logic [7:0] MEM_BASE = 8'(4 + NUM_REGS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;
  logic [CNT_W-1:0] snap_stall, snap_flush;
  logic [31:0]      snap_pc, nxt_word;
  logic [7:0]       idx, nxt;
  logic             pending, trig, start_dump;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (start_i) begin
      if (cycle_cnt != CNT_MAX)            cycle_cnt <= cycle_cnt + CNT_ONE;
      if (stall_i && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_ONE;
      if (flush_i && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

`ifdef DUMP_PERIODIC_EN
  localparam int PW = $clog2(PERIOD + 1);
  logic [PW-1:0] per_cnt;
  logic          per_hit;

  // per_hit is high in the cycle where cycle_cnt has just reached a multiple of PERIOD
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      per_cnt <= '0;
      per_hit <= 1'b0;
    end else begin
      per_hit <= 1'b0;
      if (start_i) begin
        if (per_cnt == PW'(PERIOD - 1)) begin
          per_cnt <= '0;
          per_hit <= 1'b1;
        end else begin
          per_cnt <= per_cnt + PW'(1);
        end
      end
    end
  end

  assign trig = trig_i | per_hit;
`else
  assign trig = trig_i;
`endif

  // Debug read ports are addressed by the word that will be loaded on the next transfer.
  assign nxt        = idx + 8'd1;
  assign reg_addr_o = 5'(nxt - REG_BASE);
  assign mem_addr_o = (nxt >= MEM_BASE) ? {22'd0, nxt - MEM_BASE, 2'b00} : 32'd0;
  assign freeze_o   = busy_o;

  always_comb begin
    nxt_word = mem_data_i;
    if (nxt == 8'd1)         nxt_word = snap_pc;
    else if (nxt == 8'd2)    nxt_word = 32'(snap_stall);
    else if (nxt == 8'd3)    nxt_word = 32'(snap_flush);
    else if (nxt < MEM_BASE) nxt_word = reg_data_i;
  end

  assign start_dump = (state == IDLE && trig) ||
                      (state == SEND && dump_ready_i && idx == LAST_TAG && (pending || trig));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      idx          <= '0;
      pending      <= 1'b0;
      snap_pc      <= '0;
      snap_stall   <= '0;
      snap_flush   <= '0;
      dump_valid_o <= 1'b0;
      dump_data_o  <= '0;
      dump_tag_o   <= '0;
      dump_last_o  <= 1'b0;
      busy_o       <= 1'b0;
    end else if (start_dump) begin
      state        <= SEND;
      idx          <= '0;
      pending      <= 1'b0;
      snap_pc      <= pc_i;
      snap_stall   <= stall_cnt;
      snap_flush   <= flush_cnt;
      dump_valid_o <= 1'b1;
      dump_data_o  <= 32'(cycle_cnt);
      dump_tag_o   <= '0;
      dump_last_o  <= 1'b0;
      busy_o       <= 1'b1;
    end else if (state == SEND) begin
      if (trig) pending <= 1'b1;
      if (dump_ready_i) begin
        if (idx == LAST_TAG) begin
          state        <= IDLE;
          dump_valid_o <= 1'b0;
          dump_last_o  <= 1'b0;
          busy_o       <= 1'b0;
        end else begin
          idx         <= nxt;
          dump_data_o <= nxt_word;
          dump_tag_o  <= nxt;
          dump_last_o <= (nxt == LAST_TAG);
        end
      end
    end
  end
endmodule

// File: tb/tb_cpu_state_dumper.sv
// Randomized self-checking bench for cpu_state_dumper; narrow counters exercise saturation.
module tb_cpu_state_dumper;
  localparam int NR = 32, MW = 8, CW = 4, LT = 3 + NR + MW;
  localparam longint MAXC = (longint'(1) << CW) - 1;

  logic        clk_i = 1'b0, rst_i = 1'b0, start_i = 1'b0, trig_i = 1'b0;
  logic        stall_i = 1'b0, flush_i = 1'b0, dump_ready_i = 1'b0;
  logic [31:0] pc_i = 32'd0, reg_data_i, mem_data_i, mem_addr_o, dump_data_o;
  logic [4:0]  reg_addr_o;
  logic [7:0]  dump_tag_o;
  logic        dump_valid_o, dump_last_o, busy_o, freeze_o;

  logic [31:0] regs[NR];
  logic [31:0] mem[MW];
  int checks = 0, failures = 0;
  longint m_cyc = 0, m_stall = 0, m_flush = 0, s_cyc, s_stall, s_flush;
  logic [31:0] s_pc;

  cpu_state_dumper #(.NUM_REGS(NR), .MEM_WORDS(MW), .CNT_W(CW), .PERIOD(15)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .trig_i(trig_i),
    .stall_i(stall_i), .flush_i(flush_i), .pc_i(pc_i),
    .reg_addr_o(reg_addr_o), .reg_data_i(reg_data_i),
    .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
    .dump_valid_o(dump_valid_o), .dump_ready_i(dump_ready_i),
    .dump_data_o(dump_data_o), .dump_tag_o(dump_tag_o), .dump_last_o(dump_last_o),
    .busy_o(busy_o), .freeze_o(freeze_o)
  );

  always #5 clk_i = ~clk_i;

  always_comb reg_data_i = regs[reg_addr_o];
  always_comb mem_data_i = (mem_addr_o < 32'(4 * MW)) ? mem[mem_addr_o[4:2]] : 32'h0;

  function automatic longint sat_inc(longint v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  // Counter model advances with the inputs present at the coming edge.
  task automatic tick();
    if (!rst_i) begin
      m_cyc = 0; m_stall = 0; m_flush = 0;
    end else if (start_i) begin
      m_cyc = sat_inc(m_cyc);
      if (stall_i) m_stall = sat_inc(m_stall);
      if (flush_i) m_flush = sat_inc(m_flush);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic snap();
    s_cyc = m_cyc; s_pc = pc_i; s_stall = m_stall; s_flush = m_flush;
  endtask

  function automatic logic [31:0] exp_word(int t);
    if (t == 0) return 32'(s_cyc);
    if (t == 1) return s_pc;
    if (t == 2) return 32'(s_stall);
    if (t == 3) return 32'(s_flush);
    if (t < 4 + NR) return regs[t-4];
    return mem[t-4-NR];
  endfunction

  task automatic drain();
    for (int g = 0; g < 200 && dump_valid_o; g++) tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    tick(); tick();
    checks++;
    if ({dump_valid_o, busy_o, freeze_o, dump_last_o} !== 4'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {dump_valid_o, busy_o, freeze_o, dump_last_o});
    end
    checks++;
    if (dump_tag_o !== 8'd0 || dump_data_o !== 32'd0) begin
      failures++; $display("FAIL reset_word got tag=%0d data=%h exp tag=0 data=0", dump_tag_o, dump_data_o);
    end
    rst_i = 1'b1;
    tick();
    checks++;
    if (dump_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++; $display("FAIL reset_release got valid=%b busy=%b exp 0 0", dump_valid_o, busy_o);
    end
  endtask

  task automatic test_dump();
    start_i = 1'b1; pc_i = 32'd40;
    for (int i = 0; i < 10; i++) begin
      stall_i = (i == 1 || i == 4 || i == 7);
      flush_i = (i == 5);
      tick();
    end
    start_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    dump_ready_i = 1'b1;
    snap();
    trig_i = 1'b1; tick(); trig_i = 1'b0;
    checks++;
    if (dump_valid_o !== 1'b1 || dump_tag_o !== 8'd0 || busy_o !== 1'b1 || freeze_o !== 1'b1) begin
      failures++;
      $display("FAIL first_word_latency got valid=%b tag=%0d busy=%b freeze=%b exp 1 0 1 1",
               dump_valid_o, dump_tag_o, busy_o, freeze_o);
    end
    for (int k = 0; k <= LT; k++) begin
      pc_i = $urandom;
      checks++;
      if (dump_valid_o !== 1'b1 || dump_tag_o !== 8'(k) || dump_data_o !== exp_word(k) ||
          dump_last_o !== (k == LT)) begin
        failures++;
        $display("FAIL dump_word got valid=%b tag=%0d data=%h last=%b exp tag=%0d data=%h last=%b",
                 dump_valid_o, dump_tag_o, dump_data_o, dump_last_o, k, exp_word(k), k == LT);
      end
      tick();
    end
    checks++;
    if (dump_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++; $display("FAIL dump_end got valid=%b busy=%b exp 0 0", dump_valid_o, busy_o);
    end
  endtask

  task automatic test_backpressure();
    int k = 0;
    logic hold = 1'b0;
    logic [40:0] prev = '0;
    start_i = 1'b1; dump_ready_i = 1'b0; pc_i = $urandom;
    snap();
    trig_i = 1'b1; tick(); trig_i = 1'b0;
    for (int cyc = 0; cyc < 400 && k <= LT; cyc++) begin
      dump_ready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
      stall_i = 1'($urandom); flush_i = 1'($urandom); pc_i = $urandom;
      if (hold) begin
        checks++;
        if ({dump_tag_o, dump_data_o, dump_last_o} !== prev) begin
          failures++; $display("FAIL bp_stable got %h exp %h", {dump_tag_o, dump_data_o, dump_last_o}, prev);
        end
      end
      if (dump_valid_o !== 1'b1) begin
        checks++; failures++;
        $display("FAIL bp_valid_drop got valid=%b exp 1 at word %0d", dump_valid_o, k);
      end else if (dump_ready_i) begin
        checks++;
        if (dump_tag_o !== 8'(k) || dump_data_o !== exp_word(k) || dump_last_o !== (k == LT)) begin
          failures++;
          $display("FAIL bp_word got tag=%0d data=%h last=%b exp tag=%0d data=%h last=%b",
                   dump_tag_o, dump_data_o, dump_last_o, k, exp_word(k), k == LT);
        end
        k++;
      end
      hold = dump_valid_o && !dump_ready_i;
      prev = {dump_tag_o, dump_data_o, dump_last_o};
      tick();
    end
    start_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; dump_ready_i = 1'b1;
    checks++;
    if (k != LT + 1 || dump_valid_o !== 1'b0) begin
      failures++; $display("FAIL bp_total got xfers=%0d valid=%b exp xfers=%0d valid=0", k, dump_valid_o, LT + 1);
    end
  endtask

  task automatic test_back_to_back();
    start_i = 1'b1; dump_ready_i = 1'b1; pc_i = $urandom;
    snap();
    trig_i = 1'b1; tick(); trig_i = 1'b0;
    for (int w = 0; w < 2 * (LT + 1); w++) begin
      int k = w % (LT + 1);
      stall_i = 1'($urandom); flush_i = 1'($urandom); pc_i = $urandom;
      checks++;
      if (dump_valid_o !== 1'b1 || dump_tag_o !== 8'(k) || dump_data_o !== exp_word(k)) begin
        failures++;
        $display("FAIL b2b_word got valid=%b tag=%0d data=%h exp valid=1 tag=%0d data=%h (word %0d)",
                 dump_valid_o, dump_tag_o, dump_data_o, k, exp_word(k), w);
      end
      trig_i = (w == 10 || w == 20);
      if (w == LT) snap();
      tick();
    end
    trig_i = 1'b0; start_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    checks++;
    if (dump_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++; $display("FAIL b2b_extra_dump got valid=%b busy=%b exp 0 0", dump_valid_o, busy_o);
    end
  endtask

  task automatic test_reset_mid();
    start_i = 1'b1; dump_ready_i = 1'b1; pc_i = $urandom;
    snap();
    trig_i = 1'b1; tick(); trig_i = 1'b0;
    for (int k = 0; k <= 17; k++) begin
      checks++;
      if (dump_tag_o !== 8'(k) || dump_data_o !== exp_word(k)) begin
        failures++; $display("FAIL rm_word got tag=%0d data=%h exp tag=%0d data=%h", dump_tag_o, dump_data_o, k, exp_word(k));
      end
      if (k < 17) tick();
    end
    rst_i = 1'b0; tick(); rst_i = 1'b1;
    checks++;
    if (dump_valid_o !== 1'b0 || dump_last_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++; $display("FAIL rm_abort got valid=%b last=%b busy=%b exp 0 0 0", dump_valid_o, dump_last_o, busy_o);
    end
    for (int i = 0; i < 3; i++) tick();
    start_i = 1'b0; pc_i = $urandom;
    snap();
    trig_i = 1'b1; tick(); trig_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dump_valid_o !== 1'b1 || dump_tag_o !== 8'(k) || dump_data_o !== exp_word(k)) begin
        failures++;
        $display("FAIL rm_restart got valid=%b tag=%0d data=%h exp valid=1 tag=%0d data=%h",
                 dump_valid_o, dump_tag_o, dump_data_o, k, exp_word(k));
      end
      tick();
    end
    drain();
    checks++;
    if (dump_valid_o !== 1'b0) begin
      failures++; $display("FAIL rm_drain got valid=%b exp 0", dump_valid_o);
    end
  endtask

  task automatic test_saturation();
    start_i = 1'b1; stall_i = 1'b1; flush_i = 1'b0; dump_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    start_i = 1'b0; stall_i = 1'b0; pc_i = $urandom;
    snap();
    trig_i = 1'b1; tick(); trig_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dump_tag_o !== 8'(k) || dump_data_o !== exp_word(k)) begin
        failures++; $display("FAIL sat_word got tag=%0d data=%h exp tag=%0d data=%h", dump_tag_o, dump_data_o, k, exp_word(k));
      end
      tick();
    end
    drain();
    checks++;
    if (dump_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++; $display("FAIL sat_drain got valid=%b busy=%b exp 0 0", dump_valid_o, busy_o);
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) regs[i] = $urandom;
    for (int i = 0; i < MW; i++) mem[i] = $urandom;
    regs[0] = 32'd0;
    mem[0]  = 32'd5;
    test_reset();
    test_dump();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_state_dumper.md
Name: cpu_state_dumper

Overview:
- Hardware-side producer of architectural-state snapshots for the pipelined CPU.
- On a trigger it latches the cycle, stall and flush counters and the PC, then walks the register-file debug read port and the data-memory debug read port.
- It streams every word out over a valid/ready interface, so post-silicon and FPGA runs yield the same per-cycle dump the simulation bench prints.
- It sits beside the CPU top, fed by hazard-detection stall/flush pulses and the PC output.

Parameters:
- NUM_REGS, 32, register-file entries walked (tags 4..4+NUM_REGS-1).
- MEM_WORDS, 8, 32-bit data-memory words walked from byte address 0x00 in steps of 4.
- CNT_W, 32, width of the cycle, stall and flush counters; each saturates at all-ones.
- PERIOD, 15, auto-trigger interval in cycles; used only with DUMP_PERIODIC_EN.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous reset, active-low.
- start_i  in  1  CPU running; the counters advance only while it is 1.
- trig_i  in  1  single-cycle dump request.
- stall_i  in  1  stall pulse from hazard detection.
- flush_i  in  1  flush pulse from hazard detection.
- pc_i  in  32  current PC.
- reg_addr_o  out  5  register debug read address (combinational from the walk index).
- reg_data_i  in  32  register debug read data (combinational, same cycle).
- mem_addr_o  out  32  data-memory byte address (combinational from the walk index).
- mem_data_i  in  32  data-memory word at mem_addr_o (combinational, same cycle).
- dump_valid_o  out  1  output word valid.
- dump_ready_i  in  1  consumer accepts the word.
- dump_data_o  out  32  output word.
- dump_tag_o  out  8  word index within the dump.
- dump_last_o  out  1  final word of the dump.
- busy_o  out  1  dump in progress.
- freeze_o  out  1  request that the CPU hold state; equals busy_o.

Behaviour:
- Reset (rst_i=0 at an edge):
  - All counters, outputs and pending flags go to 0; state goes to IDLE.
  - Reset applied mid-dump drops dump_valid_o on the next edge; no dump_last_o is emitted.
- Counters:
  - cycle_cnt increments every cycle that start_i=1.
  - stall_cnt increments when stall_i=1 and start_i=1; flush_cnt likewise for flush_i.
  - All counters saturate at all-ones and never wrap.
  - Counters keep running during a dump.
- Word order (L = 3 + NUM_REGS + MEM_WORDS):
  - tag 0: cycle_cnt snapshot.
  - tag 1: pc_i snapshot.
  - tag 2: stall_cnt snapshot.
  - tag 3: flush_cnt snapshot.
  - tags 4..3+NUM_REGS: reg_data_i at reg_addr_o = tag-4.
  - remaining tags up to L: mem_data_i at mem_addr_o = 4*(tag-4-NUM_REGS).
  - L = 43 at the defaults.
- Snapshots:
  - Tags 0-3 are captured at the trigger edge.
  - Register and memory words are sampled live in the cycle the word is loaded into the output register; freeze_o lets the CPU keep them coherent.
- States:
  - IDLE: trigger accepted.
  - SEND: output register holds the word with tag idx.
- IDLE -> SEND on trig_i=1 at an edge.
  - Next cycle: dump_valid_o=1, tag 0, busy_o=1.
  - Latency from trigger to first valid is 1 cycle.
- Handshake:
  - A word transfers on an edge with dump_valid_o=1 and dump_ready_i=1.
  - While valid=1 and ready=0, data, tag and last are held stable.
  - After a transfer with idx<L, the next word (idx+1) loads on the same edge, giving a throughput of 1 word/cycle.
  - dump_last_o=1 only with tag L.
- End of dump: after the transfer of tag L, return to IDLE; dump_valid_o=0 and busy_o=0 the following cycle, unless a trigger is pending.
- Trigger while busy:
  - Sets a 1-deep pending flag; extra triggers are dropped.
  - On the final transfer with pending=1, go directly to tag 0 of a new dump (fresh snapshot captured at that edge) and clear pending.
  - trig_i in the same cycle as the final transfer behaves as pending.

Optional Feature:
- Macro: DUMP_PERIODIC_EN.
- Defined:
  - An internal counter generates a trigger every PERIOD cycles while start_i=1, on the cycles where cycle_cnt reaches a multiple of PERIOD.
  - It is ORed with trig_i and follows the same pending rules.
- Undefined: dumps occur only on trig_i; no period counter is present.

Test Plan:
- Reset with rst_i=0 for 2 cycles, then release -> all outputs 0, busy_o=0, state IDLE.
- start_i=1 for 10 cycles, 3 stall pulses, 1 flush pulse, pc_i=40, trig_i pulse, dump_ready_i held 1 -> 44 consecutive words:
  - tag0=10, tag1=40, tag2=3, tag3=1.
  - tag4=R0=0.
  - tag36 = memory word 0x00 = 5.
  - dump_last_o only on tag 43; busy_o low the cycle after.
- Backpressure: dump_ready_i toggles 1,0,0,1 -> no word skipped or duplicated; data/tag stable during ready=0; total transfers = 44.
- Triggers at dump word tag 10 and tag 20 -> exactly one extra dump; its tag 0 follows tag 43 with no idle cycle.
- Reset asserted at tag 17 -> dump_valid_o=0 next edge; a subsequent trigger restarts at tag 0 with counters cleared.
- DUMP_PERIODIC_EN with PERIOD=15, ready=1, no trig_i -> dumps begin after cycle_cnt 15 and 30; a period expiring mid-dump sets pending. Saturation check with CNT_W=4: 20 stall pulses -> tag2=15.
